pfx_sub_pipe: RTL

//  Pipelined parallel-prefix subtractor: diff = a - b, the inverse operation of the 16-bit KGP prefix adder.

---
 rtl/pfx_sub_pipe_pkg.sv | 36 +++
 rtl/pfx_sub_pipe_stage.sv | 50 +++++
 rtl/pfx_sub_pipe.sv | 111 +++++++++++
 3 files changed

// File: rtl/pfx_sub_pipe_pkg.sv
// Carry-status encoding and combine rules shared by the prefix subtractor and its benches.
// A resolved status carries its carry bit in bit 0.
package pfx_sub_pipe_pkg;

  typedef logic [1:0] kgp_t;

  localparam kgp_t KGP_K = 2'b00;
  localparam kgp_t KGP_P = 2'b10;
  localparam kgp_t KGP_G = 2'b11;

  function automatic kgp_t kgp(input logic x, input logic y);
    kgp_t r;
    case ({x, y})
      2'b00:   r = KGP_K;
      2'b11:   r = KGP_G;
      default: r = KGP_P;
    endcase
    return r;
  endfunction

  // hi is the more significant group: it forwards lo only while it propagates.
  function automatic kgp_t skgp(input kgp_t hi, input kgp_t lo);
    kgp_t r;
    if (hi == KGP_P) begin
      r = lo;
    end else begin
      r = hi;
    end
    return r;
  endfunction

  function automatic int level_span(input int lvl);
    return 32'sd1 <<< (lvl - 32'sd1);
  endfunction

endpackage

// File: rtl/pfx_sub_pipe_stage.sv
// One valid/ready register slice. It reloads whenever its slot is empty or being drained,
// so a full pipeline streams one item per cycle with no bubble.
module pfx_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // Next slot contents: data only moves on a real transfer, so it is stable while stalled.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
      end else begin
        data_d = data_q;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Slot register.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/pfx_sub_pipe.sv
// Two-stage pipelined KGP parallel-prefix subtractor (a + ~b + 1) with valid/ready handshake
// and borrow / signed-overflow / zero flags.
module pfx_sub_pipe
  import pfx_sub_pipe_pkg::*;
#(
  parameter int W     = 16,
  parameter int SPLIT = $clog2(W) / 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] diff,
  output logic         borrow,
  output logic         ovf,
  output logic         zero
);

  localparam int L   = $clog2(W);
  localparam int S1W = 3 * W + 2;
  localparam int S2W = W + 3;

  logic [W-1:0][1:0] cur1_s, nxt1_s, cur2_s, nxt2_s, st1_q_s;
  logic [W-1:0]      p_s, p1_q_s, diff_s;
  logic [W:0]        c_s;
  logic              a_msb_q_s, b_msb_q_s, s1_valid, s1_adv;
  logic [S1W-1:0]    s1_in_s, s1_out_s;
  logic [S2W-1:0]    s2_in_s, s2_out_s;

  assign p_s = a ^ ~b;

  // Stage 1: per-bit status (bit 0 folded with the carry-in G) and the low prefix levels.
  always_comb begin
    cur1_s = '0;
    nxt1_s = '0;
    for (int i = 0; i < W; i++) begin
      cur1_s[i] = kgp(a[i], ~b[i]);
    end
    cur1_s[0] = skgp(cur1_s[0], KGP_G);
    for (int lv = 1; lv <= SPLIT; lv++) begin
      for (int i = 0; i < W; i++) begin
        if (i >= level_span(lv)) begin
          nxt1_s[i] = skgp(cur1_s[i], cur1_s[i-level_span(lv)]);
        end else begin
          nxt1_s[i] = cur1_s[i];
        end
      end
      cur1_s = nxt1_s;
    end
  end

  assign s1_in_s = {a[W-1], b[W-1], p_s, cur1_s};

  pfx_pipe_stage #(.WIDTH(S1W)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_in_s),
    .out_valid (s1_valid),
    .out_ready (s1_adv),
    .out_data  (s1_out_s)
  );

  assign {a_msb_q_s, b_msb_q_s, p1_q_s, st1_q_s} = s1_out_s;

  // Stage 2: remaining prefix levels, then sum bits and flags ahead of the output register.
  always_comb begin
    cur2_s = st1_q_s;
    nxt2_s = '0;
    for (int lv = SPLIT + 1; lv <= L; lv++) begin
      for (int i = 0; i < W; i++) begin
        if (i >= level_span(lv)) begin
          nxt2_s[i] = skgp(cur2_s[i], cur2_s[i-level_span(lv)]);
        end else begin
          nxt2_s[i] = cur2_s[i];
        end
      end
      cur2_s = nxt2_s;
    end
    c_s    = '0;
    c_s[0] = 1'b1;
    for (int i = 1; i <= W; i++) begin
      c_s[i] = cur2_s[i-1][0];
    end
    diff_s = p1_q_s ^ c_s[W-1:0];
  end

  assign s2_in_s = {diff_s,
                    ~c_s[W],
                    (a_msb_q_s != b_msb_q_s) && (diff_s[W-1] != a_msb_q_s),
                    (diff_s == {W{1'b0}})};

  pfx_pipe_stage #(.WIDTH(S2W)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_ready  (s1_adv),
    .in_data   (s2_in_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_out_s)
  );

  assign {diff, borrow, ovf, zero} = s2_out_s;

endmodule
